ddr_burst_wr: RTL

DDR_BURST_WR -- requirements
Module: ddr_burst_wr

---
 rtl/ddr_wr_pkg.sv | 18 +
 rtl/ddr_burst_wr_if.sv | 23 ++
 rtl/ddr_wr_skid.sv | 65 ++++++
 rtl/ddr_burst_wr.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ddr_wr_pkg.sv
// Shared definitions for the DDR burst writer: FSM state encoding, the
// Avalon burstcount width and the BURST_LEN legality check.
package ddr_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int BURSTCOUNT_W = 7;

    function automatic bit burst_len_legal(input int len);
        return (len >= 2) && (len <= 64) && ((len & (len - 1)) == 0);
    endfunction

endpackage

// File: rtl/ddr_burst_wr_if.sv
// Avalon-MM burst write channel between the burst writer (master) and DDR.
interface ddr_burst_wr_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 25
);
    import ddr_wr_pkg::*;

    logic [ADDR_W-1:0]       avm_address;
    logic                    avm_write;
    logic [DATA_W-1:0]       avm_writedata;
    logic [BURSTCOUNT_W-1:0] avm_burstcount;
    logic                    avm_waitrequest;

    modport master (
        output avm_address, avm_write, avm_writedata, avm_burstcount,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_write, avm_writedata, avm_burstcount,
        output avm_waitrequest
    );
endinterface

// File: rtl/ddr_wr_skid.sv
// Two-entry skid register decoupling FIFO read latency from DDR waitrequest.
module ddr_wr_skid #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]        occ_q, occ_d;

    // Next-entry logic; e0 is always the oldest word.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    e0_d = push_data;
                end else begin
                    e1_d = push_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    e0_d = e1_q;
                    e1_d = push_data;
                end else begin
                    e0_d = push_data;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign head = e0_q;
    assign occ  = occ_q;

endmodule

// File: rtl/ddr_burst_wr.sv
// Moves fixed-length bursts from a sample FIFO into a DDR ring buffer.
// Optional macro DDR_WR_STALL_STAT_EN adds the stall_cnt statistics output.
module ddr_burst_wr
    import ddr_wr_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 25,
    parameter int BURST_LEN = 16,
    parameter int BUF_WORDS = 1 << 20,
    parameter int BASE_ADDR = 0
) (
    input  logic               ddr_clk,
    input  logic               reset_syn,
    input  logic               enable,
    input  logic [DATA_W-1:0]  fifo_q,
    input  logic [10:0]        fifo_rdusedw,
    output logic               fifo_rdreq,
    ddr_burst_wr_if.master     avm,
    output logic               busy,
    output logic [ADDR_W-1:0]  wr_ptr,
    output logic [15:0]        wrap_cnt
`ifdef DDR_WR_STALL_STAT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    localparam int                PTR_W     = ADDR_W + 1;
    localparam logic [6:0]        LEN_C     = 7'(BURST_LEN);
    localparam logic [10:0]       USEDW_THR = 11'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BASE_C    = ADDR_W'(BASE_ADDR);
    localparam logic [PTR_W-1:0]  END_ADDR  = PTR_W'(BASE_ADDR + BUF_WORDS);

    if (!burst_len_legal(BURST_LEN) || ((BUF_WORDS % BURST_LEN) != 0)) begin : g_bad_cfg
        $error("ddr_burst_wr: illegal BURST_LEN / BUF_WORDS combination");
    end

    state_t            state_q, state_d;
    logic              fill_q, fill_d;
    logic [6:0]        reads_q, reads_d;
    logic [6:0]        beats_q, beats_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [15:0]       wrap_q, wrap_d;
    logic              rdreq_s, write_s, pop_s;
    logic [2:0]        occ_after_s;
    logic [PTR_W-1:0]  next_ptr_s;
    logic [DATA_W-1:0] skid_head_s;
    logic [1:0]        skid_occ_s;

    // FIFO data lands one cycle after the read strobe, so push is the delayed strobe.
    ddr_wr_skid #(.DATA_W(DATA_W)) u_skid (
        .clk       (ddr_clk),
        .rst       (reset_syn),
        .push      (inflight_q),
        .push_data (fifo_q),
        .pop       (pop_s),
        .head      (skid_head_s),
        .occ       (skid_occ_s)
    );

    // Next-state, read-issue and pointer-advance logic.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        reads_d     = reads_q;
        beats_d     = beats_q;
        wr_ptr_d    = wr_ptr_q;
        wrap_d      = wrap_q;
        rdreq_s     = 1'b0;
        write_s     = 1'b0;
        pop_s       = 1'b0;
        occ_after_s = 3'd0;
        next_ptr_s  = {1'b0, wr_ptr_q} + PTR_W'(BURST_LEN);
        case (state_q)
            ST_IDLE: begin
                if (enable && (fifo_rdusedw >= USEDW_THR)) begin
                    state_d = ST_FILL;
                    fill_d  = 1'b0;
                    reads_d = 7'd0;
                    beats_d = 7'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                rdreq_s = 1'b1;
                reads_d = reads_q + 7'd1;
                if (fill_q) begin
                    state_d = ST_BURST;
                end else begin
                    fill_d = 1'b1;
                end
            end
            ST_BURST: begin
                write_s     = (skid_occ_s != 2'd0);
                pop_s       = write_s && !avm.avm_waitrequest;
                // Occupancy once this cycle's pop and the landing read settle.
                occ_after_s = {1'b0, skid_occ_s} + {2'b00, inflight_q} - {2'b00, pop_s};
                if ((reads_q < LEN_C) && (occ_after_s <= 3'd1)) begin
                    rdreq_s = 1'b1;
                    reads_d = reads_q + 7'd1;
                end else begin
                    rdreq_s = 1'b0;
                end
                if (pop_s) begin
                    beats_d = beats_q + 7'd1;
                    if (beats_q == (LEN_C - 7'd1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BURST;
                    end
                end else begin
                    beats_d = beats_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (next_ptr_s == END_ADDR) begin
                    wr_ptr_d = BASE_C;
                    if (wrap_q != 16'hFFFF) begin
                        wrap_d = wrap_q + 16'd1;
                    end else begin
                        wrap_d = wrap_q;
                    end
                end else begin
                    wr_ptr_d = next_ptr_s[ADDR_W-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign inflight_d = rdreq_s;

    // Control and pointer registers.
    always_ff @(posedge ddr_clk) begin
        if (reset_syn) begin
            state_q    <= ST_IDLE;
            fill_q     <= 1'b0;
            reads_q    <= 7'd0;
            beats_q    <= 7'd0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= BASE_C;
            wrap_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            reads_q    <= reads_d;
            beats_q    <= beats_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            wrap_q     <= wrap_d;
        end
    end

`ifdef DDR_WR_STALL_STAT_EN
    logic [31:0] stall_q, stall_d;

    // Saturating count of stalled write cycles.
    always_comb begin
        if (write_s && avm.avm_waitrequest && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge ddr_clk) begin
        if (reset_syn) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign fifo_rdreq         = rdreq_s;
    assign avm.avm_write      = write_s;
    assign avm.avm_writedata  = skid_head_s;
    assign avm.avm_address    = wr_ptr_q;
    assign avm.avm_burstcount = BURSTCOUNT_W'(BURST_LEN);
    assign busy               = (state_q != ST_IDLE);
    assign wr_ptr             = wr_ptr_q;
    assign wrap_cnt           = wrap_q;

endmodule
